// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator with built-in test patterns.
// Walks a 12-bit (h,v) position through active, front porch, sync and back
// porch, and presents registered timing decodes plus a test pattern one
// enabled cycle behind the counters.
//
// Ports:
//   clk_i          pixel clock
//   rst_i          synchronous active-high reset
//   cen_i          video clock enable; nothing advances while low
//   pattern_sel_i  0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid
//   vh_blank_o     {Vblank, Hblank}
//   dvh_sync_o     {D_sync (data enable), Vsync, Hsync}
//   vid_rgb_o      {R, G, B}, black whenever D_sync is low
//   pix_x_o        horizontal position of the presented pixel
//   pix_y_o        vertical position of the presented pixel
//   sof_o          high while presenting position (0,0)
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned H_FP       = 88,
  parameter int unsigned H_SYNC     = 44,
  parameter int unsigned H_BP       = 148,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 36,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned CHECK_LOG2 = 5,
  parameter logic [23:0] SOLID_RGB  = 24'hD0_10_80
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cen_i,
  input  logic [1:0]  pattern_sel_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output logic [23:0] vid_rgb_o,
  output logic [11:0] pix_x_o,
  output logic [11:0] pix_y_o,
  output logic        sof_o
);

  localparam int unsigned CW      = 12;
  localparam int unsigned RGB_W   = 24;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [RGB_W-1:0] WHITE = 24'hFF_FF_FF;
  localparam logic [RGB_W-1:0] BLACK = 24'h00_00_00;

  // Raster position and the pattern in force for the current frame.
  logic [CW-1:0] h_q;
  logic [CW-1:0] v_q;
  logic [1:0]    pat_q;

  logic          h_wrap_c;
  logic          v_wrap_c;
  logic [CW-1:0] h_next_c;
  logic [CW-1:0] v_next_c;

  logic          hblank_c;
  logic          vblank_c;
  logic          de_c;
  logic          hsync_c;
  logic          vsync_c;
  logic          sof_c;
  logic [2:0]    bar_idx_c;
  logic [RGB_W-1:0] bar_rgb_c;
  logic [RGB_W-1:0] rgb_c;

  // Next raster position.
  always_comb begin
    h_wrap_c = (h_q == H_LAST);
    v_wrap_c = (v_q == V_LAST);
    h_next_c = h_q + CW'(1);
    v_next_c = v_q;
    if (h_wrap_c) begin
      h_next_c = '0;
      v_next_c = v_wrap_c ? '0 : (v_q + CW'(1));
    end
  end

  // Timing decodes of the current position.
  always_comb begin
    hblank_c = (h_q >= H_ACT);
    vblank_c = (v_q >= V_ACT);
    de_c     = !hblank_c && !vblank_c;
    hsync_c  = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_POL : !HS_POL;
    // Vsync spans whole lines, so it depends on v only.
    vsync_c  = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_POL : !VS_POL;
    sof_c    = (h_q == '0) && (v_q == '0);
  end

  // Colour bar index from comparators at multiples of the bar width.
  always_comb begin
    bar_idx_c = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_q >= CW'(i * BAR_W)) begin
        bar_idx_c = 3'(i);
      end
    end
  end

  // Colour bar palette.
  always_comb begin
    bar_rgb_c = BLACK;
    case (bar_idx_c)
      3'd0:    bar_rgb_c = 24'hFF_FF_FF;
      3'd1:    bar_rgb_c = 24'hFF_FF_00;
      3'd2:    bar_rgb_c = 24'h00_FF_FF;
      3'd3:    bar_rgb_c = 24'h00_FF_00;
      3'd4:    bar_rgb_c = 24'hFF_00_FF;
      3'd5:    bar_rgb_c = 24'hFF_00_00;
      3'd6:    bar_rgb_c = 24'h00_00_FF;
      default: bar_rgb_c = 24'h00_00_00;
    endcase
  end

  // Pattern pixel, blanked outside the active area.
  always_comb begin
    rgb_c = BLACK;
    if (de_c) begin
      case (pat_q)
        2'd0:    rgb_c = bar_rgb_c;
        2'd1:    rgb_c = {h_q[7:0], h_q[7:0], h_q[7:0]};
        2'd2:    rgb_c = (h_q[CHECK_LOG2] ^ v_q[CHECK_LOG2]) ? BLACK : WHITE;
        default: rgb_c = SOLID_RGB;
      endcase
    end
  end

  // Counters, per-frame pattern latch and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q        <= '0;
      v_q        <= '0;
      pat_q      <= 2'd0;
      vh_blank_o <= 2'b11;
      dvh_sync_o <= {1'b0, !VS_POL, !HS_POL};
      vid_rgb_o  <= '0;
      pix_x_o    <= '0;
      pix_y_o    <= '0;
      sof_o      <= 1'b0;
    end else if (cen_i) begin
      h_q <= h_next_c;
      v_q <= v_next_c;
      // Loading only on the wrap to (0,0) keeps a whole frame on one pattern.
      if (h_wrap_c && v_wrap_c) begin
        pat_q <= pattern_sel_i;
      end
      vh_blank_o <= {vblank_c, hblank_c};
      dvh_sync_o <= {de_c, vsync_c, hsync_c};
      vid_rgb_o  <= rgb_c;
      pix_x_o    <= h_q;
      pix_y_o    <= v_q;
      sof_o      <= sof_c;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a small 24x8 raster.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int CL = 2;
  localparam logic [23:0] SOLID = 24'hD01080;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cen_i = 1'b0;
  logic [1:0]  pattern_sel_i = 2'd0;
  logic [1:0]  vh_blank_o;
  logic [2:0]  dvh_sync_o;
  logic [23:0] vid_rgb_o;
  logic [11:0] pix_x_o;
  logic [11:0] pix_y_o;
  logic        sof_o;

  always #5 clk_i = ~clk_i;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CHECK_LOG2(CL), .SOLID_RGB(SOLID)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .pattern_sel_i(pattern_sel_i),
    .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o), .vid_rgb_o(vid_rgb_o),
    .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .sof_o(sof_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: frame position as a linear enabled-cycle index.
  int          m_cnt = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [1:0]  e_blank;
  logic [2:0]  e_sync;
  logic [23:0] e_rgb;
  int          e_x, e_y;
  logic        e_sof;
  int          tick_n = 0;

  logic [23:0] line0_rgb [HT];
  logic        line0_hs  [HT];
  logic        line0_hb  [HT];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] ref_rgb(input int x, input int y, input logic [1:0] p);
    logic [7:0] g;
    if (x >= HA || y >= VA) return 24'h0;
    g = 8'(x);
    case (p)
      2'd0:    return BARS[x / (HA / 8)];
      2'd1:    return {g, g, g};
      2'd2:    return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return SOLID;
    endcase
  endfunction

  task automatic tick(input bit cen, input bit rst);
    int x, y;
    cen_i = cen;
    rst_i = rst;
    @(posedge clk_i);
    tick_n++;
    if (rst) begin
      m_cnt = 0; m_pat = 2'd0;
      e_blank = 2'b11; e_sync = 3'b000; e_rgb = 24'h0; e_x = 0; e_y = 0; e_sof = 1'b0;
    end else if (cen) begin
      x = m_cnt % HT;
      y = m_cnt / HT;
      e_blank = {y >= VA, x >= HA};
      e_sync  = {(x < HA) && (y < VA), (y >= VA + VF) && (y < VA + VF + VS),
                 (x >= HA + HF) && (x < HA + HF + HS)};
      e_rgb   = ref_rgb(x, y, m_pat);
      e_x = x; e_y = y; e_sof = (m_cnt == 0);
      m_cnt = (m_cnt + 1) % FT;
      if (m_cnt == 0) m_pat = pattern_sel_i;
    end
    #1;
    chk("vh_blank", 32'(vh_blank_o), 32'(e_blank));
    chk("dvh_sync", 32'(dvh_sync_o), 32'(e_sync));
    chk("vid_rgb",  32'(vid_rgb_o),  32'(e_rgb));
    chk("pix_x",    32'(pix_x_o),    32'(e_x));
    chk("pix_y",    32'(pix_y_o),    32'(e_y));
    chk("sof",      32'(sof_o),      32'(e_sof));
    if (pix_y_o == 12'd0 && pix_x_o < 12'(HT)) begin
      line0_rgb[pix_x_o] = vid_rgb_o;
      line0_hs[pix_x_o]  = dvh_sync_o[0];
      line0_hb[pix_x_o]  = vh_blank_o[0];
    end
  endtask

  initial begin
    int sof_cnt, vs_cnt, de_cnt, n, last_zero;
    bit found;

    // Reset with the enable low still loads reset values.
    tick(1'b0, 1'b1);
    chk("rst_blank", 32'(vh_blank_o), 32'h3);
    chk("rst_sync",  32'(dvh_sync_o), 32'h0);
    chk("rst_rgb",   32'(vid_rgb_o),  32'h0);
    chk("rst_sof",   32'(sof_o),      32'h0);

    // First frame, colour bars, continuous enable.
    sof_cnt = 0; vs_cnt = 0; de_cnt = 0;
    for (int i = 0; i < FT; i++) begin
      tick(1'b1, 1'b0);
      if (i == 0) begin
        chk("first_sof", 32'(sof_o), 32'h1);
        chk("first_de",  32'(dvh_sync_o[2]), 32'h1);
        chk("first_x",   32'(pix_x_o), 32'h0);
      end
      sof_cnt += int'(sof_o);
      vs_cnt  += int'(dvh_sync_o[1]);
      de_cnt  += int'(dvh_sync_o[2]);
    end
    chk("sof_per_frame", 32'(sof_cnt), 32'd1);
    chk("vsync_cycles",  32'(vs_cnt),  32'd48);
    chk("de_cycles",     32'(de_cnt),  32'd64);
    chk("bar_x0",  32'(line0_rgb[0]),  32'hFFFFFF);
    chk("bar_x1",  32'(line0_rgb[1]),  32'hFFFFFF);
    chk("bar_x2",  32'(line0_rgb[2]),  32'hFFFF00);
    chk("bar_x10", 32'(line0_rgb[10]), 32'hFF0000);
    chk("bar_x14", 32'(line0_rgb[14]), 32'h000000);
    for (int x = 16; x < HT; x++) chk("bar_blank", 32'(line0_rgb[x]), 32'h0);
    chk("hs_x17", 32'(line0_hs[17]), 32'h0);
    for (int x = 18; x <= 20; x++) chk("hs_on", 32'(line0_hs[x]), 32'h1);
    chk("hs_x21", 32'(line0_hs[21]), 32'h0);
    chk("hb_x15", 32'(line0_hb[15]), 32'h0);
    chk("hb_x16", 32'(line0_hb[16]), 32'h1);
    chk("hb_x23", 32'(line0_hb[23]), 32'h1);

    // Mid-frame pattern change only takes effect at the next frame.
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      tick(1'b1, 1'b0);
      found = (pix_y_o == 12'd1 && pix_x_o == 12'd5);
    end
    chk("reach_y1x5", 32'(found), 32'h1);
    pattern_sel_i = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      tick(1'b1, 1'b0);
      found = (sof_o == 1'b1);
    end
    chk("reach_sof", 32'(found), 32'h1);
    for (int i = 0; i < HT - 1; i++) tick(1'b1, 1'b0);
    for (int x = 0; x < 4; x++)  chk("chk_x0_3",  32'(line0_rgb[x]), 32'hFFFFFF);
    for (int x = 4; x < 8; x++)  chk("chk_x4_7",  32'(line0_rgb[x]), 32'h000000);
    for (int x = 8; x < 12; x++) chk("chk_x8_11", 32'(line0_rgb[x]), 32'hFFFFFF);

    // Alternating enable: outputs hold on gaps, a line spans 48 clocks.
    last_zero = -1;
    for (int i = 0; i < 4 * FT; i++) begin
      tick((i % 2) == 0, 1'b0);
      if ((i % 2) == 0 && pix_x_o == 12'd0) begin
        if (last_zero >= 0) chk("line_clocks", 32'(tick_n - last_zero), 32'd48);
        last_zero = tick_n;
      end
    end

    // Randomized enable and pattern selection.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) pattern_sel_i = 2'($urandom_range(0, 3));
      tick($urandom_range(0, 3) != 0, 1'b0);
    end

    // Reset mid-frame with the enable low.
    found = 1'b0;
    n = 0;
    while (!found && n < 2 * FT) begin
      tick(1'b1, 1'b0);
      found = (pix_y_o == 12'd2 && pix_x_o == 12'd7);
      n++;
    end
    chk("reach_y2x7", 32'(found), 32'h1);
    tick(1'b0, 1'b1);
    chk("mrst_blank", 32'(vh_blank_o), 32'h3);
    chk("mrst_sync",  32'(dvh_sync_o), 32'h0);
    chk("mrst_rgb",   32'(vid_rgb_o),  32'h0);
    chk("mrst_x",     32'(pix_x_o),    32'h0);
    chk("mrst_y",     32'(pix_y_o),    32'h0);
    chk("mrst_sof",   32'(sof_o),      32'h0);
    tick(1'b1, 1'b0);
    chk("post_sof",  32'(sof_o),      32'h1);
    chk("post_x",    32'(pix_x_o),    32'h0);
    chk("post_y",    32'(pix_y_o),    32'h0);
    chk("post_sync", 32'(dvh_sync_o), 32'h4);
    chk("post_rgb",  32'(vid_rgb_o),  32'hFFFFFF);
    for (int i = 0; i < FT; i++) tick(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
